team_06_i2s_tx_scheduler: RTL and testbench

- Sequences the I2S transmit path to the DAC and shares it between two 16-bit sample requesters, e.g. the synth voice and the playback buffer.
- Generates bclk and ws from the system clock and grants one requester per slot (left, then right) by round-robin.
- Serialises the granted word MSB-first with the standard I2S one-bit delay, and substitutes silence on underrun.

---
 rtl/team_06_i2s_tx_scheduler.sv | 229 ++++++++++++++++++++++
 tb/tb_team_06_i2s_tx_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/team_06_i2s_tx_scheduler.sv
// team_06_i2s_tx_scheduler
// Shares the I2S transmit path to the DAC between two 16-bit sample requesters.
// Generates bclk/ws from clk and grants one requester per slot (left, then right)
// by round-robin. The granted word is serialised MSB-first with the standard
// one-bit delay after ws. A slot with no valid requester carries silence.
//
// Optional build macro: TEAM_06_I2S_MONO_DUP_EN adds mono_en; when high, the
// right slot repeats the left word without arbitrating.
//
// Ports:
//   clk, rst            system clock, asynchronous active-low reset
//   enable              run request (IDLE->RUN, RUN->DRAIN)
//   mono_en             (macro builds only) duplicate left word into right slot
//   src0_*/src1_*       requester data/valid in, ready out (combinational grant)
//   bclk, ws, sdata     I2S bit clock, word select (0 = left), serial data
//   frame_start         one-clk pulse following the left-slot grant point
//   underrun            one-clk pulse following an empty grant point
//   underrun_cnt        saturating underrun count, cleared only by reset
`timescale 1ns/1ps
module team_06_i2s_tx_scheduler #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned BCLK_DIV = 4,
  parameter int unsigned UCNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
`ifdef TEAM_06_I2S_MONO_DUP_EN
  input  logic              mono_en,
`endif
  input  logic [DATA_W-1:0] src0_data,
  input  logic              src0_valid,
  output logic              src0_ready,
  input  logic [DATA_W-1:0] src1_data,
  input  logic              src1_valid,
  output logic              src1_ready,
  output logic              bclk,
  output logic              ws,
  output logic              sdata,
  output logic              frame_start,
  output logic              underrun,
  output logic [UCNT_W-1:0] underrun_cnt
);

  localparam int unsigned DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(DATA_W);
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_TC = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  state_t            state_d;

  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] shift;
  logic              rr;          // 1: src1 has priority on a tie

  logic              mono_c;
  logic              fall_c;
  logic              entry_c;
  logic              grant_c;
  logic              stop_c;
  logic              arb_c;
  logic              take0_c;
  logic              take1_c;
  logic              underrun_c;
  logic              new_ws_c;

`ifdef TEAM_06_I2S_MONO_DUP_EN
  assign mono_c = mono_en;
`else
  assign mono_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state, grant point detection and arbitration
  always_comb begin
    state_d    = state;
    fall_c     = 1'b0;
    entry_c    = 1'b0;
    grant_c    = 1'b0;
    stop_c     = 1'b0;
    arb_c      = 1'b0;
    take0_c    = 1'b0;
    take1_c    = 1'b0;
    underrun_c = 1'b0;
    new_ws_c   = 1'b0;

    // bclk is about to fall in this cycle
    fall_c = (state != IDLE) && (div_cnt == DIV_TC) && bclk;

    case (state)
      IDLE: begin
        if (enable) begin
          entry_c = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = DRAIN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    grant_c  = entry_c || (fall_c && (bit_cnt == BIT_TC));
    new_ws_c = entry_c ? 1'b0 : ~ws;

    // While draining, the next left grant point ends the run instead of granting
    stop_c = grant_c && (state == DRAIN) && ws;
    if (stop_c) begin
      state_d = IDLE;
    end

    // Mono right slot reuses the held left word and skips arbitration
    arb_c = grant_c && !stop_c && !(mono_c && new_ws_c);

    if (arb_c) begin
      if (src0_valid && (!src1_valid || !rr)) begin
        take0_c = 1'b1;
      end else if (src1_valid) begin
        take1_c = 1'b1;
      end else begin
        underrun_c = 1'b1;
      end
    end
  end

  assign src0_ready = take0_c;
  assign src1_ready = take1_c;

  // Bit clock, serialiser, hold register, arbitration pointer and status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt      <= '0;
      bit_cnt      <= '0;
      bclk         <= 1'b0;
      ws           <= 1'b0;
      sdata        <= 1'b0;
      hold         <= '0;
      shift        <= '0;
      rr           <= 1'b0;
      frame_start  <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;

      if (entry_c || stop_c) begin
        // Entry behaves like a falling edge with ws=0 and a zero delay bit
        div_cnt <= '0;
        bit_cnt <= '0;
        bclk    <= 1'b0;
        ws      <= 1'b0;
        sdata   <= 1'b0;
      end else if (state != IDLE) begin
        if (div_cnt == DIV_TC) begin
          div_cnt <= '0;
          bclk    <= ~bclk;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end

        if (fall_c) begin
          if (bit_cnt == BIT_TC) begin
            bit_cnt <= '0;
            ws      <= ~ws;
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
          end

          // First fall after the grant point starts the new word; the
          // grant-point fall itself shifts out the previous word's LSB.
          if (bit_cnt == '0) begin
            shift <= hold;
            sdata <= hold[DATA_W-1];
          end else begin
            shift <= shift << 1;
            sdata <= shift[DATA_W-2];
          end
        end
      end

      if (take0_c) begin
        hold <= src0_data;
        rr   <= 1'b1;
      end else if (take1_c) begin
        hold <= src1_data;
        rr   <= 1'b0;
      end else if (underrun_c) begin
        hold <= '0;
      end

      if (underrun_c) begin
        underrun <= 1'b1;
        if (underrun_cnt != '1) begin
          underrun_cnt <= underrun_cnt + UCNT_W'(1);
        end
      end

      if (grant_c && !stop_c && !new_ws_c) begin
        frame_start <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_team_06_i2s_tx_scheduler.sv
// Testbench for team_06_i2s_tx_scheduler (DATA_W=16, BCLK_DIV=2).
// Stimulus drives one slot at a time from its grant point; the expected word for
// each slot is queued from a bench-side arbitration model and compared against
// words recovered from bclk/ws/sdata by an I2S receiver thread.
`timescale 1ns/1ps
module tb_team_06_i2s_tx_scheduler;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned BCLK_DIV = 2;
  localparam int unsigned UCNT_W   = 8;
  localparam int          SLOT_CLK = 2 * BCLK_DIV * DATA_W;

  logic              clk;
  logic              rst;
  logic              enable;
  logic              mono_en;
  logic [DATA_W-1:0] src0_data;
  logic              src0_valid;
  logic              src0_ready;
  logic [DATA_W-1:0] src1_data;
  logic              src1_valid;
  logic              src1_ready;
  logic              bclk;
  logic              ws;
  logic              sdata;
  logic              frame_start;
  logic              underrun;
  logic [UCNT_W-1:0] underrun_cnt;

  team_06_i2s_tx_scheduler #(
    .DATA_W   (DATA_W),
    .BCLK_DIV (BCLK_DIV),
    .UCNT_W   (UCNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
`ifdef TEAM_06_I2S_MONO_DUP_EN
    .mono_en      (mono_en),
`endif
    .src0_data    (src0_data),
    .src0_valid   (src0_valid),
    .src0_ready   (src0_ready),
    .src1_data    (src1_data),
    .src1_valid   (src1_valid),
    .src1_ready   (src1_ready),
    .bclk         (bclk),
    .ws           (ws),
    .sdata        (sdata),
    .frame_start  (frame_start),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int                n_tot;
  int                n_bad;
  logic [DATA_W-1:0] sb_q[$];

  // Bench model of the arbiter and slot sequence
  logic              m_rr;
  logic              m_ws;
  logic              m_entry;
  logic              m_drain;
  logic              m_mono;
  logic [DATA_W-1:0] m_last;
  int                m_ucnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // I2S receiver: samples on bclk rise, a ws change marks the LSB of the previous word
  task automatic rx_loop();
    logic              pb;
    logic              act;
    logic              rws;
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] w;
    logic [DATA_W-1:0] e;
    int                n;
    int                low;
    pb  = 1'b0;
    act = 1'b0;
    rws = 1'b0;
    sh  = '0;
    n   = 0;
    low = 0;
    forever begin
      @(negedge clk);
      if (bclk && !pb) begin
        low = 0;
        if (!act || (ws != rws)) begin
          if (act) begin
            chk("word_len", 32'(n), 32'(DATA_W - 1));
            w = {sh[DATA_W-2:0], sdata};
            if (sb_q.size() == 0) begin
              chk("sb_empty", 32'(sb_q.size()), 32'd1);
            end else begin
              e = sb_q.pop_front();
              chk("sb_word", 32'(w), 32'(e));
            end
          end else begin
            chk("delay_bit", 32'(sdata), 32'd0);
          end
          act = 1'b1;
          rws = ws;
          n   = 0;
          sh  = '0;
        end else begin
          sh = {sh[DATA_W-2:0], sdata};
          n++;
        end
      end else if (!bclk) begin
        if (low < 1000) low++;
        if ((low == 3 * BCLK_DIV) && act) begin
          // Run stopped: the final word's LSB slot is never clocked out
          if (n == DATA_W - 1) begin
            if (sb_q.size() == 0) begin
              chk("sb_empty", 32'(sb_q.size()), 32'd1);
            end else begin
              e = sb_q.pop_front();
              chk("sb_tail", 32'(sh[DATA_W-2:0]), 32'(e[DATA_W-1:1]));
            end
          end
          act = 1'b0;
        end
      end
      pb = bclk;
    end
  endtask

  // Runs one slot starting at the negedge of its grant cycle.
  // act 1: drop enable at cycle act_at; act 2: assert reset at cycle act_at and return.
  task automatic slot(input logic v0, input logic [DATA_W-1:0] d0,
                      input logic v1, input logic [DATA_W-1:0] d1,
                      input int act_at, input int act);
    logic nws, stp, arb, e0, e1, eu, esd, stray;
    src0_data  = d0;
    src1_data  = d1;
    src0_valid = v0;
    src1_valid = v1;
    if (m_entry) enable = 1'b1;
    nws = m_entry ? 1'b0 : ~m_ws;
    esd = m_entry ? 1'b0 : m_last[0];
    stp = m_drain && !nws;
    arb = !stp && !(m_mono && nws);
    e0  = arb && v0 && (!v1 || !m_rr);
    e1  = arb && v1 && !e0;
    eu  = arb && !v0 && !v1;
    #1;
    chk("ready0", 32'(src0_ready), 32'(e0));
    chk("ready1", 32'(src1_ready), 32'(e1));
    if (e0) begin
      m_last = d0;
      m_rr   = 1'b1;
    end else if (e1) begin
      m_last = d1;
      m_rr   = 1'b0;
    end else if (eu) begin
      m_last = '0;
      if (m_ucnt < 255) m_ucnt++;
    end
    if (!stp) sb_q.push_back(m_last);
    m_entry = 1'b0;

    @(negedge clk);
    src0_valid = 1'b0;
    src1_valid = 1'b0;
    if (stp) begin
      chk("stop_bclk", 32'(bclk), 32'd0);
      chk("stop_ws", 32'(ws), 32'd0);
      chk("stop_sdata", 32'(sdata), 32'd0);
      chk("stop_fs", 32'(frame_start), 32'd0);
      chk("stop_ur", 32'(underrun), 32'd0);
      m_drain = 1'b0;
      m_entry = 1'b1;
      m_ws    = 1'b0;
      return;
    end
    chk("ws", 32'(ws), 32'(nws));
    chk("sdata_lsb", 32'(sdata), 32'(esd));
    chk("frame_start", 32'(frame_start), 32'(!nws));
    chk("underrun", 32'(underrun), 32'(eu));
    chk("underrun_cnt", 32'(underrun_cnt), 32'(m_ucnt));
    m_ws  = nws;
    stray = src0_ready | src1_ready;
    for (int i = 2; i <= SLOT_CLK; i++) begin
      @(negedge clk);
      if (i == 2) chk("pulse_len", 32'({frame_start, underrun}), 32'd0);
      if (i < SLOT_CLK) stray = stray | src0_ready | src1_ready;
      if (i == act_at) begin
        if (act == 1) begin
          enable  = 1'b0;
          m_drain = 1'b1;
        end else if (act == 2) begin
          rst = 1'b0;
          #1;
          chk("arst_bclk", 32'(bclk), 32'd0);
          chk("arst_ws", 32'(ws), 32'd0);
          chk("arst_sdata", 32'(sdata), 32'd0);
          chk("arst_ucnt", 32'(underrun_cnt), 32'd0);
          chk("arst_ready", 32'({src0_ready, src1_ready}), 32'd0);
          chk("ready_quiet", 32'(stray), 32'd0);
          return;
        end
      end
    end
    chk("ready_quiet", 32'(stray), 32'd0);
  endtask

  task automatic model_reset();
    m_rr    = 1'b0;
    m_ws    = 1'b0;
    m_entry = 1'b1;
    m_drain = 1'b0;
    m_mono  = 1'b0;
    m_last  = '0;
    m_ucnt  = 0;
  endtask

  initial begin
    n_tot      = 0;
    n_bad      = 0;
    rst        = 1'b0;
    enable     = 1'b0;
    mono_en    = 1'b0;
    src0_data  = '0;
    src0_valid = 1'b0;
    src1_data  = '0;
    src1_valid = 1'b0;
    model_reset();
    fork
      rx_loop();
    join_none

    // Reset values
    #400;
    @(negedge clk);
    chk("rst_bclk", 32'(bclk), 32'd0);
    chk("rst_ws", 32'(ws), 32'd0);
    chk("rst_sdata", 32'(sdata), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_ur", 32'(underrun), 32'd0);
    chk("rst_ucnt", 32'(underrun_cnt), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_bclk", 32'(bclk), 32'd0);

    // Startup
    slot(1'b1, 16'hD9D3, 1'b0, 16'h0000, 0, 0);
    slot(1'b0, 16'h0000, 1'b1, 16'h1234, 0, 0);

    // Round-robin with both requesters valid
    for (int k = 0; k < 6; k++) slot(1'b1, 16'h9933, 1'b1, 16'h1234, 0, 0);

    // Underruns up to saturation
    for (int k = 0; k < 300; k++) slot(1'b0, 16'h0000, 1'b0, 16'h0000, 0, 0);
    chk("ucnt_sat", 32'(underrun_cnt), 32'd255);

    // Drain: drop enable during the left slot
    if (!m_ws) slot(1'b1, 16'h7E81, 1'b0, 16'h0000, 0, 0);
    slot(1'b1, 16'hA1B2, 1'b0, 16'h0000, 21, 1);
    slot(1'b0, 16'h0000, 1'b1, 16'hC3D4, 0, 0);
    slot(1'b1, 16'hEEEE, 1'b1, 16'hFFFF, 0, 0);
    src0_valid = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_hold_bclk", 32'(bclk), 32'd0);
    chk("idle_hold_ws", 32'(ws), 32'd0);
    chk("idle_no_ready", 32'(src0_ready), 32'd0);
    src0_valid = 1'b0;

    // Mid-operation reset during the right slot
    slot(1'b1, 16'h5A5A, 1'b0, 16'h0000, 0, 0);
    slot(1'b0, 16'h0000, 1'b1, 16'h0F0F, 30, 2);
    sb_q.delete();
    repeat (100) @(negedge clk);
    chk("rst_hold_bclk", 32'(bclk), 32'd0);
    chk("rst_hold_ucnt", 32'(underrun_cnt), 32'd0);
    model_reset();
    rst = 1'b1;
    slot(1'b1, 16'hD9D3, 1'b0, 16'h0000, 0, 0);
    slot(1'b1, 16'h1111, 1'b1, 16'h2222, 0, 0);
    slot(1'b1, 16'h3333, 1'b1, 16'h4444, 0, 0);
    slot(1'b1, 16'h5555, 1'b1, 16'h6666, 0, 0);

`ifdef TEAM_06_I2S_MONO_DUP_EN
    // Mono duplication: right slot repeats the left word, no grant, no underrun
    mono_en = 1'b1;
    m_mono  = 1'b1;
    slot(1'b1, 16'hA5A5, 1'b0, 16'h0000, 0, 0);
    slot(1'b1, 16'hA5A5, 1'b0, 16'h0000, 0, 0);
    slot(1'b1, 16'hA5A5, 1'b1, 16'h3C3C, 0, 0);
    slot(1'b0, 16'h0000, 1'b0, 16'h0000, 0, 0);
    mono_en = 1'b0;
    m_mono  = 1'b0;
    slot(1'b1, 16'hB6B6, 1'b1, 16'hC7C7, 0, 0);
    slot(1'b1, 16'hB6B6, 1'b1, 16'hC7C7, 0, 0);
`endif

    repeat (8) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
